// File: rtl/ddr3_cmd_responder.sv
// ddr3_cmd_responder: device-side DDR3 command checker and BL8 read model.
// Tracks 8 banks, enforces tRCD/tRP/tRAS/tCCD, returns reads CL cycles later.
module ddr3_cmd_responder #(
  parameter int CL   = 6,
  parameter int TRCD = 6,
  parameter int TRP  = 6,
  parameter int TRAS = 15,
  parameter int TCCD = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cke,
  input  logic         cs_n,
  input  logic         ras_n,
  input  logic         cas_n,
  input  logic         we_n,
  input  logic         odt,
  input  logic [2:0]   ba,
  input  logic [13:0]  addr,
  output logic         rd_valid,
  output logic [511:0] rd_data,
  output logic         err,
  output logic [2:0]   err_code,
  output logic         err_pulse,
  output logic [31:0]  act_cnt,
  output logic [31:0]  rd_cnt,
  output logic [31:0]  wr_cnt,
  output logic [31:0]  pre_cnt,
  output logic [31:0]  ref_cnt
);

  localparam logic [4:0] SAT = 5'd31;

  typedef struct packed {
    logic        v;
    logic [2:0]  ba;
    logic [13:0] row;
    logic [6:0]  col;
  } rd_slot_t;

  logic [7:0]  open_q;
  logic [13:0] row_q [8];
  logic [4:0]  since_act_q [8];
  logic [4:0]  since_pre_q [8];
  logic [4:0]  since_rw_q;
  rd_slot_t    pipe_q [CL];
  rd_slot_t    slot_d;

  logic         rd_valid_q;
  logic [511:0] rd_data_q;
  logic         err_q;
  logic [2:0]   err_code_q;
  logic         err_pulse_q;
  logic [31:0]  act_cnt_q;
  logic [31:0]  rd_cnt_q;
  logic [31:0]  wr_cnt_q;
  logic [31:0]  pre_cnt_q;
  logic [31:0]  ref_cnt_q;

  logic unused_odt;
  assign unused_odt = odt;

  // Counter value c at an edge means c+1 cycles have elapsed since the event.
  function automatic logic met(input logic [4:0] cnt, input int t);
    return (int'(cnt) + 1) >= t;
  endfunction

  function automatic logic [4:0] sat_inc(input logic [4:0] c);
    return (c == SAT) ? SAT : c + 5'd1;
  endfunction

  function automatic logic [511:0] burst(input rd_slot_t s);
    logic [511:0] d;
    d = '0;
    for (int i = 0; i < 8; i++)
      d[64*i +: 64] = {16'h0000, 8'hA5, 5'b0, s.ba, 2'b0,
                       s.row, 6'b0, s.col, 3'(i)};
    return d;
  endfunction

  logic       cmd_v;
  logic [2:0] op;
  logic       is_act, is_rd, is_wr, is_pre, is_ref, is_mrs;
  logic       pre_all;

  assign cmd_v   = cke & ~cs_n;
  assign op      = {ras_n, cas_n, we_n};
  assign is_act  = cmd_v && (op == 3'b011);
  assign is_rd   = cmd_v && (op == 3'b101);
  assign is_wr   = cmd_v && (op == 3'b100);
  assign is_pre  = cmd_v && (op == 3'b010);
  assign is_ref  = cmd_v && (op == 3'b001);
  assign is_mrs  = cmd_v && (op == 3'b000);
  assign pre_all = addr[10];

  logic       tras_all_ok;
  logic [2:0] code_d;

  always_comb begin
    tras_all_ok = 1'b1;
    for (int b = 0; b < 8; b++)
      if (open_q[b] && !met(since_act_q[b], TRAS))
        tras_all_ok = 1'b0;
    code_d = 3'd0;
    unique case (1'b1)
      is_act: begin
        if (open_q[ba]) code_d = 3'd1;
        else if (!met(since_pre_q[ba], TRP)) code_d = 3'd5;
      end
      is_rd, is_wr: begin
        if (!open_q[ba]) code_d = 3'd2;
        else if (!met(since_act_q[ba], TRCD)) code_d = 3'd3;
        else if (!met(since_rw_q, TCCD)) code_d = 3'd4;
      end
      is_pre: begin
        if (pre_all ? !tras_all_ok
                    : (open_q[ba] && !met(since_act_q[ba], TRAS)))
          code_d = 3'd6;
      end
      is_ref, is_mrs: begin
        if (|open_q) code_d = 3'd7;
      end
      default: ;
    endcase
  end

  logic legal, act_ok, rd_ok, wr_ok, pre_ok, ref_ok, rw_ok;
  assign legal  = (code_d == 3'd0);
  assign act_ok = is_act && legal;
  assign rd_ok  = is_rd && legal;
  assign wr_ok  = is_wr && legal;
  assign pre_ok = is_pre && legal;
  assign ref_ok = is_ref && legal;
  assign rw_ok  = rd_ok || wr_ok;

  always_comb begin
    slot_d     = '0;
    slot_d.v   = rd_ok;
    slot_d.ba  = ba;
    slot_d.row = row_q[ba];
    slot_d.col = addr[9:3];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      open_q     <= '0;
      since_rw_q <= SAT;
      for (int b = 0; b < 8; b++) begin
        row_q[b]       <= '0;
        since_act_q[b] <= SAT;
        since_pre_q[b] <= SAT;
      end
    end else begin
      since_rw_q <= rw_ok ? 5'd0 : sat_inc(since_rw_q);
      for (int b = 0; b < 8; b++) begin
        since_act_q[b] <= sat_inc(since_act_q[b]);
        since_pre_q[b] <= sat_inc(since_pre_q[b]);
        if (act_ok && ba == 3'(b)) begin
          open_q[b]      <= 1'b1;
          row_q[b]       <= addr;
          since_act_q[b] <= 5'd0;
        end
        // PRE to an already-closed bank is a counted no-op.
        if (pre_ok && open_q[b] && (pre_all || ba == 3'(b))) begin
          open_q[b]      <= 1'b0;
          since_pre_q[b] <= 5'd0;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < CL; i++)
        pipe_q[i] <= '0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      pipe_q[0] <= slot_d;
      for (int i = 1; i < CL; i++)
        pipe_q[i] <= pipe_q[i-1];
      rd_valid_q <= pipe_q[CL-1].v;
      if (pipe_q[CL-1].v)
        rd_data_q <= burst(pipe_q[CL-1]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q       <= 1'b0;
      err_code_q  <= 3'd0;
      err_pulse_q <= 1'b0;
      act_cnt_q   <= '0;
      rd_cnt_q    <= '0;
      wr_cnt_q    <= '0;
      pre_cnt_q   <= '0;
      ref_cnt_q   <= '0;
    end else begin
      err_pulse_q <= !legal;
      if (!legal && !err_q) begin
        err_q      <= 1'b1;
        err_code_q <= code_d;
      end
      if (act_ok) act_cnt_q <= act_cnt_q + 32'd1;
      if (rd_ok)  rd_cnt_q  <= rd_cnt_q + 32'd1;
      if (wr_ok)  wr_cnt_q  <= wr_cnt_q + 32'd1;
      if (pre_ok) pre_cnt_q <= pre_cnt_q + 32'd1;
      if (ref_ok) ref_cnt_q <= ref_cnt_q + 32'd1;
    end
  end

  assign rd_valid  = rd_valid_q;
  assign rd_data   = rd_data_q;
  assign err       = err_q;
  assign err_code  = err_code_q;
  assign err_pulse = err_pulse_q;
  assign act_cnt   = act_cnt_q;
  assign rd_cnt    = rd_cnt_q;
  assign wr_cnt    = wr_cnt_q;
  assign pre_cnt   = pre_cnt_q;
  assign ref_cnt   = ref_cnt_q;

endmodule

// File: tb/tb_ddr3_cmd_responder.sv
// Bench for ddr3_cmd_responder: command vector table plus read scoreboard.
// Hand sequences cover reset-in-flight and cke/cs_n gating.
module tb_ddr3_cmd_responder;

  localparam int CL   = 6;
  localparam int TRCD = 6;
  localparam int TRP  = 6;
  localparam int TRAS = 15;
  localparam int TCCD = 4;

  localparam logic [2:0] C_NOP = 3'b111;
  localparam logic [2:0] C_ACT = 3'b011;
  localparam logic [2:0] C_RD  = 3'b101;
  localparam logic [2:0] C_WR  = 3'b100;
  localparam logic [2:0] C_PRE = 3'b010;
  localparam logic [2:0] C_REF = 3'b001;
  localparam logic [2:0] C_MRS = 3'b000;
  localparam logic [2:0] C_ZQ  = 3'b110;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cke = 1'b1;
  logic cs_n = 1'b1;
  logic ras_n = 1'b1;
  logic cas_n = 1'b1;
  logic we_n = 1'b1;
  logic odt = 1'b0;
  logic [2:0] ba = '0;
  logic [13:0] addr = '0;

  logic         rd_valid;
  logic [511:0] rd_data;
  logic         err;
  logic [2:0]   err_code;
  logic         err_pulse;
  logic [31:0]  act_cnt, rd_cnt, wr_cnt, pre_cnt, ref_cnt;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  typedef struct {
    logic [511:0] data;
    int           due;
  } exp_t;

  typedef struct {
    int          seg;
    int          idle;
    logic [2:0]  cmd;
    logic [2:0]  ba;
    logic [13:0] addr;
    logic        pulse;
    logic        err;
    logic [2:0]  code;
  } vec_t;

  exp_t        sb[$];
  exp_t        mon_e;
  vec_t        tv[$];
  logic [63:0] w5_log[$];
  logic [13:0] row_m [8];

  ddr3_cmd_responder #(
    .CL(CL), .TRCD(TRCD), .TRP(TRP), .TRAS(TRAS), .TCCD(TCCD)
  ) dut (
    .clk(clk), .rst(rst), .cke(cke), .cs_n(cs_n),
    .ras_n(ras_n), .cas_n(cas_n), .we_n(we_n), .odt(odt),
    .ba(ba), .addr(addr),
    .rd_valid(rd_valid), .rd_data(rd_data),
    .err(err), .err_code(err_code), .err_pulse(err_pulse),
    .act_cnt(act_cnt), .rd_cnt(rd_cnt), .wr_cnt(wr_cnt),
    .pre_cnt(pre_cnt), .ref_cnt(ref_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [511:0] burst(input logic [2:0] b,
                                         input logic [13:0] r,
                                         input logic [13:0] a);
    logic [511:0] d;
    d = '0;
    for (int i = 0; i < 8; i++)
      d[64*i +: 64] = {16'h0000, 8'hA5, 5'b0, b, 2'b0,
                       r, 6'b0, a[9:3], 3'(i)};
    return d;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && rd_valid) begin
      w5_log.push_back(rd_data[383:320]);
      n_cmp++;
      if (sb.size() == 0) begin
        n_bad++;
        $display("FAIL burst: unexpected rd_valid at cycle %0d", cyc);
      end else begin
        mon_e = sb.pop_front();
        if (mon_e.due != cyc || rd_data !== mon_e.data) begin
          n_bad++;
          $display("FAIL burst: cycle %0d data %h want cycle %0d data %h",
                   cyc, rd_data, mon_e.due, mon_e.data);
        end
      end
    end
  end

  task automatic add(input int s, input int idl, input logic [2:0] c,
                     input logic [2:0] b, input logic [13:0] a,
                     input logic p, input logic e, input logic [2:0] k);
    vec_t v;
    v.seg = s; v.idle = idl; v.cmd = c; v.ba = b; v.addr = a;
    v.pulse = p; v.err = e; v.code = k;
    tv.push_back(v);
  endtask

  task automatic issue(input logic k, input logic cs, input logic [2:0] c,
                       input logic [2:0] b, input logic [13:0] a);
    cke = k; cs_n = cs; {ras_n, cas_n, we_n} = c; ba = b; addr = a;
    @(posedge clk); #1;
    cke = 1'b1; cs_n = 1'b1; {ras_n, cas_n, we_n} = C_NOP;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    sb.delete();
    w5_log.delete();
    #2;
    chk("rst rd_valid", 64'(rd_valid), 64'd0);
    chk("rst rd_data", 64'(|rd_data), 64'd0);
    chk("rst err", 64'(err), 64'd0);
    chk("rst err_code", 64'(err_code), 64'd0);
    chk("rst err_pulse", 64'(err_pulse), 64'd0);
    chk("rst act_cnt", 64'(act_cnt), 64'd0);
    chk("rst rd_cnt", 64'(rd_cnt), 64'd0);
    chk("rst wr_cnt", 64'(wr_cnt), 64'd0);
    chk("rst pre_cnt", 64'(pre_cnt), 64'd0);
    chk("rst ref_cnt", 64'(ref_cnt), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    idle(2);
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d bursts pending want 0", sb.size());
    end
  endtask

  task automatic run_seg(input int s);
    do_reset();
    foreach (tv[i]) begin
      if (tv[i].seg == s) begin
        idle(tv[i].idle);
        issue(1'b1, 1'b0, tv[i].cmd, tv[i].ba, tv[i].addr);
        if (!tv[i].pulse) begin
          if (tv[i].cmd == C_ACT) row_m[tv[i].ba] = tv[i].addr;
          if (tv[i].cmd == C_RD)
            sb.push_back('{burst(tv[i].ba, row_m[tv[i].ba], tv[i].addr),
                           cyc + CL});
        end
        chk($sformatf("v%0d err_pulse", i), 64'(err_pulse), 64'(tv[i].pulse));
        chk($sformatf("v%0d err", i), 64'(err), 64'(tv[i].err));
        chk($sformatf("v%0d err_code", i), 64'(err_code), 64'(tv[i].code));
      end
    end
    drain();
  endtask

  initial begin
    for (int b = 0; b < 8; b++) row_m[b] = '0;
    // seg 1: basic read, tCCD spacing and violations
    add(1, 0, C_ACT, 3'd2, 14'h0123, 0, 0, 3'd0);
    add(1, 5, C_RD,  3'd2, 14'h0040, 0, 0, 3'd0);
    add(1, 3, C_RD,  3'd2, 14'h0048, 0, 0, 3'd0);
    add(1, 1, C_RD,  3'd2, 14'h0050, 1, 1, 3'd4);
    add(1, 0, C_WR,  3'd2, 14'h0058, 1, 1, 3'd4);
    add(1, 0, C_NOP, 3'd2, 14'h0000, 0, 1, 3'd4);
    add(1, 0, C_ZQ,  3'd2, 14'h0000, 0, 1, 3'd4);
    add(1, 0, C_WR,  3'd5, 14'h0000, 1, 1, 3'd4);
    add(1, 0, C_ACT, 3'd2, 14'h0001, 1, 1, 3'd4);
    add(1, 2, C_WR,  3'd2, 14'h0060, 0, 1, 3'd4);
    // seg 2: tRCD violation
    add(2, 0, C_ACT, 3'd0, 14'h0010, 0, 0, 3'd0);
    add(2, 4, C_RD,  3'd0, 14'h0000, 1, 1, 3'd3);
    // seg 3: tRAS, tRP, first error retained
    add(3, 0,  C_ACT, 3'd0, 14'h0002, 0, 0, 3'd0);
    add(3, 13, C_PRE, 3'd0, 14'h0000, 1, 1, 3'd6);
    add(3, 0,  C_RD,  3'd0, 14'h0008, 0, 1, 3'd6);
    add(3, 0,  C_PRE, 3'd0, 14'h0000, 0, 1, 3'd6);
    add(3, 4,  C_ACT, 3'd0, 14'h0005, 1, 1, 3'd6);
    add(3, 0,  C_ACT, 3'd0, 14'h3FFF, 0, 1, 3'd6);
    add(3, 5,  C_RD,  3'd0, 14'h03F8, 0, 1, 3'd6);
    // seg 4: PRE-all, REF, MRS
    add(4, 0,  C_ACT, 3'd1, 14'h0011, 0, 0, 3'd0);
    add(4, 0,  C_ACT, 3'd3, 14'h0033, 0, 0, 3'd0);
    add(4, 0,  C_REF, 3'd0, 14'h0000, 1, 1, 3'd7);
    add(4, 12, C_PRE, 3'd0, 14'h0400, 1, 1, 3'd7);
    add(4, 0,  C_PRE, 3'd0, 14'h0400, 0, 1, 3'd7);
    add(4, 0,  C_REF, 3'd0, 14'h0000, 0, 1, 3'd7);
    add(4, 0,  C_MRS, 3'd0, 14'h0000, 0, 1, 3'd7);
    add(4, 0,  C_PRE, 3'd4, 14'h0000, 0, 1, 3'd7);
    add(4, 5,  C_ACT, 3'd1, 14'h0100, 0, 1, 3'd7);

    @(posedge clk); #1;
    run_seg(1);
    chk("s1 act_cnt", 64'(act_cnt), 64'd1);
    chk("s1 rd_cnt", 64'(rd_cnt), 64'd2);
    chk("s1 wr_cnt", 64'(wr_cnt), 64'd1);
    chk("s1 bursts", 64'(w5_log.size()), 64'd2);
    if (w5_log.size() == 2) begin
      chk("s1 word5 a", w5_log[0], 64'h0000_A502_0123_0045);
      chk("s1 word5 b", w5_log[1], 64'h0000_A502_0123_004D);
    end

    run_seg(2);
    idle(12);
    chk("s2 rd_cnt", 64'(rd_cnt), 64'd0);
    chk("s2 act_cnt", 64'(act_cnt), 64'd1);
    chk("s2 bursts", 64'(w5_log.size()), 64'd0);

    run_seg(3);
    chk("s3 act_cnt", 64'(act_cnt), 64'd2);
    chk("s3 pre_cnt", 64'(pre_cnt), 64'd1);
    chk("s3 rd_cnt", 64'(rd_cnt), 64'd2);

    run_seg(4);
    chk("s4 act_cnt", 64'(act_cnt), 64'd3);
    chk("s4 pre_cnt", 64'(pre_cnt), 64'd2);
    chk("s4 ref_cnt", 64'(ref_cnt), 64'd1);

    // reset while a read is in flight, then cke/cs_n gating
    do_reset();
    issue(1'b1, 1'b0, C_ACT, 3'd7, 14'h0777);
    idle(TRCD - 1);
    issue(1'b1, 1'b0, C_RD, 3'd7, 14'h0100);
    idle(2);
    do_reset();
    idle(12);
    chk("rr bursts", 64'(w5_log.size()), 64'd0);
    chk("rr act_cnt", 64'(act_cnt), 64'd0);
    chk("rr rd_cnt", 64'(rd_cnt), 64'd0);
    issue(1'b0, 1'b0, C_ACT, 3'd7, 14'h0001);
    chk("cke0 act_cnt", 64'(act_cnt), 64'd0);
    chk("cke0 err_pulse", 64'(err_pulse), 64'd0);
    issue(1'b1, 1'b1, C_ACT, 3'd7, 14'h0002);
    chk("cs1 act_cnt", 64'(act_cnt), 64'd0);
    issue(1'b1, 1'b0, C_ACT, 3'd7, 14'h0003);
    chk("act7 err_pulse", 64'(err_pulse), 64'd0);
    chk("act7 act_cnt", 64'(act_cnt), 64'd1);
    chk("act7 err", 64'(err), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
